// File: rtl/csi_header_ecc.sv
// rtl/csi_header_ecc.sv - CSI-2 packet header ECC check/correct and payload forwarder
//
// Captures the 4-byte packet header from the lane-merged 16-bit stream and
// applies CSI-2 SEC-DED correction. It strobes the corrected header out, then
// forwards the long-packet payload with the trailing 2-byte CRC stripped.
// Packets whose header cannot be corrected are discarded.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   in_data[15:0]  merged byte stream, [7:0] is the earlier byte
//   in_valid       frames one packet; low for >=1 cycle between packets
//   data_stream    registered payload word, qualified by valid_stream
//   ph_stream      corrected header {WC[15:8], WC[7:0], DI}, updated on ph_select
//   ph_select      1-cycle strobe: ph_stream holds a new header
//   valid_stream   data_stream holds a payload word
//   ecc_error      header uncorrectable, pulses together with ph_select
//   truncated      1-cycle pulse when in_valid falls before payload+CRC completed
module csi_header_ecc #(
  parameter logic [5:0] LONG_DT_MIN = 6'h10,
  parameter bit         ECC_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic [15:0] data_stream,
  output logic [23:0] ph_stream,
  output logic        ph_select,
  output logic        valid_stream,
  output logic        ecc_error,
  output logic        truncated
);

  typedef enum logic [2:0] {IDLE, HDR1, PAYLOAD, CRC, DRAIN} state_t;

  // Header bits D[23:0] covered by each parity bit, listed P5 down to P0.
  localparam logic [5:0][23:0] PMASK = {
    24'hEFFC00, 24'hDF03F0, 24'hB8E38E, 24'h749A6D, 24'hF2555B, 24'hF12CB7
  };

  // Syndrome produced when only data bit k is flipped.
  function automatic logic [5:0] column(input int k);
    logic [5:0] c;
    for (int j = 0; j < 6; j++) c[j] = PMASK[j][k];
    return c;
  endfunction

  state_t      state, state_d;
  logic [15:0] hdr_lo, hdr_lo_d;
  logic [15:0] cnt, cnt_d;
  logic [15:0] data_d;
  logic [23:0] ph_d;
  logic        ph_sel_d, valid_d, ecc_err_d, trunc_d;

  logic [23:0] hdr_raw, hdr_fix;
  logic [5:0]  syndrome;
  logic        hdr_bad, hit;
  logic        is_long;
  logic [15:0] wc;

  // Word 1 is still on in_data while in HDR1, so the decode is combinational on it.
  assign hdr_raw = {in_data[7:0], hdr_lo};

  always_comb begin
    syndrome = '0;
    for (int j = 0; j < 6; j++) syndrome[j] = (^(hdr_raw & PMASK[j])) ^ in_data[8+j];
    hdr_fix = hdr_raw;
    hdr_bad = 1'b0;
    hit     = 1'b0;
    if (ECC_EN) begin
      for (int k = 0; k < 24; k++) begin
        if (syndrome == column(k)) begin
          hdr_fix[k] = ~hdr_raw[k];
          hit        = 1'b1;
        end
      end
      // Nonzero syndrome that is neither a data column nor a single parity bit.
      hdr_bad = !hit && ((syndrome & (syndrome - 6'd1)) != 6'd0);
    end
  end

  assign wc      = hdr_fix[23:8];
  assign is_long = hdr_fix[5:0] >= LONG_DT_MIN;

  always_comb begin
    state_d   = state;
    hdr_lo_d  = hdr_lo;
    cnt_d     = cnt;
    data_d    = data_stream;
    ph_d      = ph_stream;
    ph_sel_d  = 1'b0;
    valid_d   = 1'b0;
    ecc_err_d = 1'b0;
    trunc_d   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          hdr_lo_d = in_data;
          state_d  = HDR1;
        end
      end
      HDR1: begin
        if (!in_valid) begin
          trunc_d = 1'b1;
          state_d = IDLE;
        end else begin
          ph_d      = hdr_fix;
          ph_sel_d  = 1'b1;
          ecc_err_d = hdr_bad;
          if (hdr_bad || !is_long) begin
            state_d = DRAIN;
          end else if (wc == 16'd0) begin
            state_d = CRC;
          end else begin
            cnt_d   = wc;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!in_valid) begin
          trunc_d = 1'b1;
          state_d = IDLE;
        end else begin
          data_d  = in_data;
          valid_d = 1'b1;
          if (cnt <= 16'd2) begin
            // Odd WC: the upper byte of the last word is already CRC byte 0.
            if (cnt == 16'd1) data_d[15:8] = 8'h00;
            cnt_d   = 16'd0;
            state_d = CRC;
          end else begin
            cnt_d = cnt - 16'd2;
          end
        end
      end
      CRC: begin
        // One word remains in both cases: both CRC bytes, or CRC byte 1 plus pad.
        if (!in_valid) begin
          trunc_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hdr_lo       <= '0;
      cnt          <= '0;
      data_stream  <= '0;
      ph_stream    <= '0;
      ph_select    <= 1'b0;
      valid_stream <= 1'b0;
      ecc_error    <= 1'b0;
      truncated    <= 1'b0;
    end else begin
      state        <= state_d;
      hdr_lo       <= hdr_lo_d;
      cnt          <= cnt_d;
      data_stream  <= data_d;
      ph_stream    <= ph_d;
      ph_select    <= ph_sel_d;
      valid_stream <= valid_d;
      ecc_error    <= ecc_err_d;
      truncated    <= trunc_d;
    end
  end

endmodule

// File: tb/tb_csi_header_ecc.sv
// tb/tb_csi_header_ecc.sv - self-checking bench for csi_header_ecc
module tb_csi_header_ecc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] data_stream;
  logic [23:0] ph_stream;
  logic        ph_select, valid_stream, ecc_error, truncated;

  csi_header_ecc dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .data_stream(data_stream), .ph_stream(ph_stream), .ph_select(ph_select),
    .valid_stream(valid_stream), .ecc_error(ecc_error), .truncated(truncated)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Syndrome contribution of each header data bit D0..D23 (CSI-2 Hamming columns).
  localparam logic [5:0] COLS [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] p = '0;
    for (int k = 0; k < 24; k++) if (d[k]) p ^= COLS[k];
    return p;
  endfunction

  // Nearest-codeword decode: accept exact match, any single data flip or any single parity flip.
  task automatic decode(input logic [23:0] d, input logic [5:0] e,
                        output logic [23:0] fixed, output bit unc);
    bit found = 1'b0;
    fixed = d;
    if (ecc_of(d) == e) found = 1'b1;
    for (int k = 0; k < 24; k++)
      if (!found && ecc_of(d ^ (24'h1 << k)) == e) begin
        fixed = d ^ (24'h1 << k);
        found = 1'b1;
      end
    for (int j = 0; j < 6; j++)
      if (!found && ecc_of(d) == (e ^ (6'h1 << j))) found = 1'b1;
    unc = !found;
  endtask

  // Output monitor, sampled on the falling edge.
  logic [23:0] ph_q[$];
  bit          err_q[$];
  int          phc_q[$];
  logic [15:0] dat_q[$];
  int          datc_q[$];
  int          trunc_n = 0;
  int          overlap_n = 0;

  always @(negedge clk) begin
    if (ph_select) begin
      ph_q.push_back(ph_stream);
      err_q.push_back(ecc_error);
      phc_q.push_back(cyc);
    end
    if (valid_stream) begin
      dat_q.push_back(data_stream);
      datc_q.push_back(cyc);
    end
    if (truncated) trunc_n++;
    if (ph_select && valid_stream) overlap_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_pkt(input string tag, input logic [15:0] tx[$], input int n_ph,
                         input logic [23:0] exp_ph, input bit chk_ph, input bit exp_err,
                         input logic [15:0] rx[$], input int exp_trunc);
    int w1c = -1;
    int w2c = -1;
    ph_q.delete(); err_q.delete(); phc_q.delete(); dat_q.delete(); datc_q.delete();
    trunc_n = 0;
    foreach (tx[i]) begin
      @(negedge clk);
      in_data = tx[i];
      in_valid = 1'b1;
      if (i == 1) w1c = cyc;
      if (i == 2) w2c = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    check({tag, "_ph_count"}, ph_q.size(), n_ph);
    if (n_ph == 1 && ph_q.size() == 1) begin
      check({tag, "_ph_lat"}, phc_q[0], w1c + 1);
      check({tag, "_ecc_err"}, {31'b0, err_q[0]}, {31'b0, exp_err});
      if (chk_ph) begin
        check({tag, "_ph"}, {8'h0, ph_q[0]}, {8'h0, exp_ph});
        check({tag, "_ph_hold"}, {8'h0, ph_stream}, {8'h0, exp_ph});
      end
    end
    check({tag, "_word_count"}, dat_q.size(), rx.size());
    for (int i = 0; i < rx.size() && i < dat_q.size(); i++)
      check($sformatf("%s_d%0d", tag, i), {16'h0, dat_q[i]}, {16'h0, rx[i]});
    if (rx.size() > 0 && dat_q.size() > 0) begin
      check({tag, "_data_lat"}, datc_q[0], w2c + 1);
      check({tag, "_data_hold"}, {16'h0, data_stream}, {16'h0, rx[rx.size()-1]});
    end
    check({tag, "_trunc"}, trunc_n, exp_trunc);
  endtask

  task automatic pack(input logic [7:0] b[$], output logic [15:0] w[$]);
    w.delete();
    for (int i = 0; i < b.size(); i += 2)
      w.push_back({(i + 1 < b.size()) ? b[i+1] : 8'h00, b[i]});
  endtask

  typedef struct {
    logic [7:0]  di;
    logic [15:0] wc;
    logic [7:0]  ecc;
    bit          auto_ecc;
    int          ntx;
    logic [63:0] tx;
    logic [23:0] ph;
    bit          chk_ph;
    bit          err;
    int          nrx;
    logic [47:0] rx;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic [7:0]  bq[$];
    logic [7:0]  pq[$];
    logic [7:0]  e;
    logic [23:0] d, fixed;
    logic [29:0] cw;
    bit          unc;
    int          a, b2, mode;

    //          di     wc       ecc    auto ntx tx                      ph          chk err nrx rx
    vt[0] = '{8'h00, 16'h0000, 8'h00, 0, 0, 64'h0,                   24'h000000, 1, 0, 0, 48'h0};
    vt[1] = '{8'h01, 16'h0000, 8'h00, 0, 0, 64'h0,                   24'h000000, 1, 0, 0, 48'h0};
    vt[2] = '{8'h00, 16'h0000, 8'h01, 0, 0, 64'h0,                   24'h000000, 1, 0, 0, 48'h0};
    vt[3] = '{8'h00, 16'h0000, 8'hC0, 0, 0, 64'h0,                   24'h000000, 1, 0, 0, 48'h0};
    vt[4] = '{8'h03, 16'h0000, 8'h00, 0, 4, 64'h4444_3333_2222_1111, 24'h000000, 0, 1, 0, 48'h0};
    vt[5] = '{8'h2B, 16'h0006, 8'h00, 1, 4, 64'hABCD_3333_2222_1111, 24'h00062B, 1, 0, 3, 48'h3333_2222_1111};
    vt[6] = '{8'h2B, 16'h0005, 8'h00, 1, 4, 64'h00DD_CC05_0403_0201, 24'h00052B, 1, 0, 3, 48'h0005_0403_0201};
    vt[7] = '{8'h12, 16'h0000, 8'h00, 1, 1, 64'h0000_0000_0000_BEEF, 24'h000012, 1, 0, 0, 48'h0};
    vt[8] = '{8'h1E, 16'h0002, 8'h00, 1, 2, 64'h0000_0000_CAFE_5A5A, 24'h00021E, 1, 0, 1, 48'h5A5A};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data_stream", {16'h0, data_stream}, 32'h0);
    check("rst_ph_stream", {8'h0, ph_stream}, 32'h0);
    check("rst_strobes", {28'h0, ph_select, valid_stream, ecc_error, truncated}, 32'h0);

    for (int v = 0; v < 9; v++) begin
      e = vt[v].auto_ecc ? {2'b00, ecc_of({vt[v].wc, vt[v].di})} : vt[v].ecc;
      txq.delete();
      rxq.delete();
      txq.push_back({vt[v].wc[7:0], vt[v].di});
      txq.push_back({e, vt[v].wc[15:8]});
      for (int i = 0; i < vt[v].ntx; i++) txq.push_back(vt[v].tx[16*i +: 16]);
      for (int i = 0; i < vt[v].nrx; i++) rxq.push_back(vt[v].rx[16*i +: 16]);
      run_pkt($sformatf("vec%0d", v), txq, 1, vt[v].ph, vt[v].chk_ph, vt[v].err, rxq, 0);
    end

    // Drop in_valid after 2 of 4 payload words, then a clean packet must decode.
    txq = '{16'h082B, {2'b00, ecc_of(24'h00082B), 8'h00}, 16'hAAA1, 16'hAAA2};
    rxq = '{16'hAAA1, 16'hAAA2};
    run_pkt("trunc_pay", txq, 1, 24'h00082B, 1, 0, rxq, 1);
    txq = '{16'h3441, {2'b00, ecc_of(24'h123441), 8'h12}};
    rxq.delete();
    run_pkt("after_trunc", txq, 1, 24'h123441, 1, 0, rxq, 0);

    // Drop during HDR1: no header strobe.
    txq = '{16'h0000};
    run_pkt("trunc_hdr", txq, 0, 24'h0, 0, 0, rxq, 1);

    // Drop before the CRC word.
    txq = '{16'h021E, {2'b00, ecc_of(24'h00021E), 8'h00}, 16'h7788};
    rxq = '{16'h7788};
    run_pkt("trunc_crc", txq, 1, 24'h00021E, 1, 0, rxq, 1);

    // Reset in the middle of a payload.
    @(negedge clk); in_valid = 1'b1; in_data = 16'h082B;
    @(negedge clk); in_data = {2'b00, ecc_of(24'h00082B), 8'h00};
    @(negedge clk); in_data = 16'h5151;
    @(negedge clk); in_data = 16'h5252;
    @(negedge clk); in_data = 16'h5353; reset = 1'b1;
    @(negedge clk);
    check("midrst_data_stream", {16'h0, data_stream}, 32'h0);
    check("midrst_ph_stream", {8'h0, ph_stream}, 32'h0);
    check("midrst_strobes", {28'h0, ph_select, valid_stream, ecc_error, truncated}, 32'h0);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    txq = '{16'h021E, {2'b00, ecc_of(24'h00021E), 8'h00}, 16'h9A9B, 16'h1234};
    rxq = '{16'h9A9B};
    run_pkt("after_rst", txq, 1, 24'h00021E, 1, 0, rxq, 0);

    // Randomized headers with 0, 1 or 2 injected bit errors.
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  di = 8'($urandom);
      logic [15:0] wc = 16'($urandom_range(0, 12));
      d = {wc, di};
      cw = {ecc_of(d), d};
      mode = $urandom % 3;
      a = $urandom % 30;
      b2 = (a + 1 + ($urandom % 29)) % 30;
      if (mode >= 1) cw[a] = ~cw[a];
      if (mode == 2) cw[b2] = ~cw[b2];
      e = {2'($urandom), cw[29:24]};
      txq.delete();
      txq.push_back(cw[15:0]);
      txq.push_back({e, cw[23:16]});
      pq.delete();
      for (int i = 0; i < wc; i++) pq.push_back(8'($urandom));
      if (di[5:0] >= 6'h10) begin
        bq = pq;
        bq.push_back(8'($urandom));
        bq.push_back(8'($urandom));
        pack(bq, rxq);
        foreach (rxq[i]) txq.push_back(rxq[i]);
      end
      decode(cw[23:0], cw[29:24], fixed, unc);
      rxq.delete();
      if (!unc && fixed[5:0] >= 6'h10) pack(pq, rxq);
      run_pkt($sformatf("rnd%0d", n), txq, 1, fixed, !unc, unc, rxq, 0);
    end

    check("no_overlap", overlap_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
